// File: rtl/orb_stream_scheduler.sv
// orb_stream_scheduler
// Frame-level sequencer between the DMA AXI-Stream source and the ORB
// feature/match engine. It holds the engine in reset while arming, paces
// pixel beats with a clock enable (orb_ce) instead of a derived clock,
// tracks h/v position, regenerates tlast and raises line/frame interrupts.
//
// Optional build macro: ORB_SCHED_AUTO_REARM_EN
//   defined   : DONE re-enters ARM (continuous frames until cfg_abort)
//   undefined : DONE returns to IDLE; every frame needs its own cfg_start
//
// Ports
//   s_axis_aclk, s_axis_areset   clock, synchronous active-high reset
//   cfg_start / cfg_abort        frame start pulse / frame kill (abort wins)
//   cfg_mode -> mode_act         engine mode, latched when a frame starts
//   s_axis_tvalid/tlast/tready   upstream handshake (tready is combinational)
//   m_axis_tvalid/tlast/tready   downstream handshake (registered output)
//   orb_rst_n, orb_ce            engine reset (low = held) and pixel enable
//   h_cnt, v_cnt                 pixel / line position of the next beat
//   line_irq, frame_done         one-cycle completion pulses
//   err_tlast                    sticky upstream tlast mismatch
//   state                        FSM state for debug
module orb_stream_scheduler #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int CE_DIV     = 2,
  parameter int ARM_CYCLES = 4
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_areset,
  input  logic       cfg_start,
  input  logic       cfg_abort,
  input  logic [3:0] cfg_mode,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  input  logic       m_axis_tready,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       orb_rst_n,
  output logic       orb_ce,
  output logic [3:0] mode_act,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       line_irq,
  output logic       frame_done,
  output logic       err_tlast,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [2:0]       PACE_LAST = 3'(CE_DIV - 1);
  localparam logic [9:0]       H_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       V_LAST    = 10'(V_ACTIVE - 1);

  state_t           state_q, state_d;
  logic [ARM_W-1:0] arm_cnt;
  logic [2:0]       pace;
  logic             out_free, accept, exp_last, frame_end, start_go, rearm;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == RUN) && (pace == 3'd0) && out_free;
  // An abort cycle never counts as a pixel, even if upstream saw tready.
  assign accept        = s_axis_tvalid && s_axis_tready && !cfg_abort;
  assign exp_last      = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  // Either an early upstream tlast or the geometric last pixel ends the frame.
  assign frame_end     = accept && (exp_last || s_axis_tlast);
  assign start_go      = (state_q == IDLE) && cfg_start && !cfg_abort;
`ifdef ORB_SCHED_AUTO_REARM_EN
  assign rearm         = (state_q == DONE) && !cfg_abort;
`else
  assign rearm         = 1'b0;
`endif

  assign orb_rst_n  = state_q inside {RUN, DRAIN, DONE};
  assign orb_ce     = (state_q == RUN) && (pace == 3'd0);
  assign frame_done = (state_q == DONE) && !cfg_abort;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = ARM;
      ARM:     if (arm_cnt == ARM_LAST) state_d = RUN;
      RUN:     if (frame_end) state_d = DRAIN;
      DRAIN:   if (out_free) state_d = DONE;
`ifdef ORB_SCHED_AUTO_REARM_EN
      DONE:    state_d = ARM;
`else
      DONE:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    if (cfg_abort) state_d = IDLE;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q       <= IDLE;
      arm_cnt       <= '0;
      pace          <= '0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      line_irq      <= 1'b0;
      err_tlast     <= 1'b0;
      mode_act      <= '0;
    end else begin
      state_q  <= state_d;
      line_irq <= accept && (h_cnt == H_LAST);

      // Counters restart at every frame start; they hold after the frame so
      // software can read the final position.
      if (start_go || rearm) begin
        arm_cnt <= '0;
        pace    <= '0;
        h_cnt   <= '0;
        v_cnt   <= '0;
      end else begin
        if (state_q == ARM) arm_cnt <= arm_cnt + 1'b1;
        if (state_q == RUN) pace <= (pace == PACE_LAST) ? 3'd0 : pace + 3'd1;
        if (accept) begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= v_cnt + 10'd1;
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
        end
      end

      if (start_go) begin
        mode_act  <= cfg_mode;
        err_tlast <= 1'b0;
      end else if (accept && (s_axis_tlast != exp_last)) begin
        err_tlast <= 1'b1;
      end

      // Output beat register: holds until the downstream consumes it.
      if (cfg_abort) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= exp_last || s_axis_tlast;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule
